// File: rtl/gpio_in_pkg.sv
// ---------------------------------------------------------------------------
// gpio_in_pkg
// Shared constants and helpers for the GPIO input conditioning slice.
//   GPIO_IN_WIDTH           : width of the Avalon GPIO in_port being fed
//   DEFAULT_DEBOUNCE_CYCLES : stable cycles before an output moves (10 ms @ 50 MHz)
//   DEFAULT_SYNC_STAGES     : flops in each metastability synchroniser
//   cntWidth()              : debounce counter width, clog2 with a floor of 1
// ---------------------------------------------------------------------------
package gpio_in_pkg;

   localparam int GPIO_IN_WIDTH           = 4;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int DEFAULT_SYNC_STAGES     = 2;

   // A single-cycle debounce still needs a one-bit counter so the
   // declarations downstream never collapse to zero width.
   function automatic int cntWidth(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/gpio_in_debounce_bit.sv
// ---------------------------------------------------------------------------
// gpio_in_debounce_bit
// One conditioned input bit: synchroniser chain, debounce counter, stable
// level register and registered rise/fall pulses.
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   pin_in     : raw asynchronous pin
//   stable_out : debounced level
//   rise_pulse : one-cycle pulse when stable_out goes 0->1
//   fall_pulse : one-cycle pulse when stable_out goes 1->0
//   changing   : high while the debounce counter is non-zero
// ---------------------------------------------------------------------------
module gpio_in_debounce_bit
   import gpio_in_pkg::*;
#(
   parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic RESET_BIT       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_in,
   output logic stable_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic changing
);

   localparam int            CW       = cntWidth(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_stable;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_sync;

   // Synchroniser: the raw pin only ever touches the first flop of this
   // chain; everything downstream works from the last stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= {SYNC_STAGES{RESET_BIT}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

   // Debounce: count consecutive cycles where the synchronised level
   // disagrees with the stable level. Any agreement restarts the count, so
   // short glitches leave nothing behind. The counter clears when it hits
   // its last value, so it can never wrap. Pulses are registered alongside
   // the stable update so they line up with the new stable_out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_stable <= RESET_BIT;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (w_sync == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
            r_rise   <= w_sync;
            r_fall   <= ~w_sync;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign stable_out = r_stable;
   assign rise_pulse = r_rise;
   assign fall_pulse = r_fall;
   assign changing   = (r_cnt != '0);

endmodule

// File: rtl/gpio_in_conditioner.sv
// ---------------------------------------------------------------------------
// gpio_in_conditioner
// Input conditioning stage in front of the Avalon GPIO input port. Each pin
// is synchronised and debounced independently; stable_out feeds in_port.
// Ports:
//   clk          : system clock
//   reset        : asynchronous, active-high reset
//   pin_in       : raw asynchronous pins (switches/buttons)
//   stable_out   : debounced levels, to GPIO in_port
//   rise_pulse   : one-cycle pulse per bit on a stable 0->1 change
//   fall_pulse   : one-cycle pulse per bit on a stable 1->0 change
//   changing     : per bit, high while that bit is mid-debounce
//   edge_clear   : per-bit clear strobe for edge_capture (GPIO_IN_EDGE_LATCH_EN)
//   edge_capture : sticky rising-edge flags (GPIO_IN_EDGE_LATCH_EN)
// Build option: define GPIO_IN_EDGE_LATCH_EN to add the sticky edge latch.
// ---------------------------------------------------------------------------
module gpio_in_conditioner
   import gpio_in_pkg::*;
#(
   parameter int               WIDTH           = GPIO_IN_WIDTH,
   parameter int               SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] stable_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic [WIDTH-1:0] changing
`ifdef GPIO_IN_EDGE_LATCH_EN
   ,
   input  logic [WIDTH-1:0] edge_clear,
   output logic [WIDTH-1:0] edge_capture
`endif
);

   // One independent conditioner per bit; bits never interact, so several
   // may pulse in the same cycle.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      gpio_in_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_BIT       (RESET_VALUE[gi])
      ) u_bit (
         .clk        (clk),
         .reset      (reset),
         .pin_in     (pin_in[gi]),
         .stable_out (stable_out[gi]),
         .rise_pulse (rise_pulse[gi]),
         .fall_pulse (fall_pulse[gi]),
         .changing   (changing[gi])
      );
   end

`ifdef GPIO_IN_EDGE_LATCH_EN
   logic [WIDTH-1:0] r_edgeCapture;

   // Sticky rising-edge flags. The set term is OR-ed in after the clear so
   // a rise arriving in the same cycle as its clear is never lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_edgeCapture <= '0;
      end else begin
         r_edgeCapture <= (r_edgeCapture & ~edge_clear) | rise_pulse;
      end
   end

   assign edge_capture = r_edgeCapture;
`else
   // Edge latch not built: no extra ports or state.
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// ---------------------------------------------------------------------------
// tb_gpio_in_conditioner
// Scoreboard bench for gpio_in_conditioner (WIDTH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, RESET_VALUE=0). A reference model pushes the expected
// outputs after every clock edge; a monitor pops and compares on the falling
// edge. Honours GPIO_IN_EDGE_LATCH_EN when defined.
// ---------------------------------------------------------------------------
module tb_gpio_in_conditioner;

   localparam int W = 4;
   localparam int S = 2;
   localparam int D = 4;
   localparam int H = S + D;

   logic         clk    = 1'b0;
   logic         reset  = 1'b1;
   logic [W-1:0] pin_in = '0;
   logic [W-1:0] stable_out;
   logic [W-1:0] rise_pulse;
   logic [W-1:0] fall_pulse;
   logic [W-1:0] changing;
`ifdef GPIO_IN_EDGE_LATCH_EN
   logic [W-1:0] edge_clear = '0;
   logic [W-1:0] edge_capture;
`endif

   typedef struct packed {
      logic [W-1:0] stable;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic [W-1:0] chg;
`ifdef GPIO_IN_EDGE_LATCH_EN
      logic [W-1:0] cap;
`endif
   } exp_t;

   exp_t expQ[$];
   int   testsRun    = 0;
   int   testsFailed = 0;

   gpio_in_conditioner #(
      .WIDTH           (W),
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D),
      .RESET_VALUE     (4'b0000)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pin_in       (pin_in),
      .stable_out   (stable_out),
      .rise_pulse   (rise_pulse),
      .fall_pulse   (fall_pulse),
      .changing     (changing)
`ifdef GPIO_IN_EDGE_LATCH_EN
      ,
      .edge_clear   (edge_clear),
      .edge_capture (edge_capture)
`endif
   );

   // 100 MHz-ish free-running clock for the bench.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Drive pins for a number of cycles; always entered and left 2 time
   // units after a rising edge so inputs never move near the sampling edge.
   task automatic applyStimulus(input logic [W-1:0] pins, input int cycles);
      pin_in = pins;
      repeat (cycles) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Reference model: keep the raw pin history per edge. The level the
   // debouncer sees at an edge is the pin sampled S edges earlier; a bit
   // moves once the last D such levels all disagree with its stable level.
   logic [W-1:0] hist [H];
   logic [W-1:0] mStable;
   logic [W-1:0] mRise;
   logic [W-1:0] mCap;

   always @(posedge clk or posedge reset) begin : model
      exp_t e;
      logic allMis;
      if (reset) begin
         for (int k = 0; k < H; k++) hist[k] = '0;
         mStable = '0;
         mRise   = '0;
         mCap    = '0;
         expQ.delete();
      end else begin
         for (int k = H - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = pin_in;
         e = '0;
         for (int b = 0; b < W; b++) begin
            allMis = 1'b1;
            for (int k = S; k < H; k++)
               if (hist[k][b] == mStable[b]) allMis = 1'b0;
            if (allMis) begin
               mStable[b] = hist[S][b];
               if (hist[S][b]) e.rise[b] = 1'b1;
               else            e.fall[b] = 1'b1;
            end else begin
               e.chg[b] = (hist[S][b] != mStable[b]);
            end
         end
         e.stable = mStable;
`ifdef GPIO_IN_EDGE_LATCH_EN
         mCap  = (mCap & ~edge_clear) | mRise;
         e.cap = mCap;
`endif
         mRise = e.rise;
         expQ.push_back(e);
      end
   end

   // Monitor: one expected entry per clock edge, compared mid-cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("stable_out", stable_out, e.stable);
         checkOutput("rise_pulse", rise_pulse, e.rise);
         checkOutput("fall_pulse", fall_pulse, e.fall);
         checkOutput("changing",   changing,   e.chg);
         checkOutput("rise_fall_overlap", rise_pulse & fall_pulse, 4'b0000);
`ifdef GPIO_IN_EDGE_LATCH_EN
         checkOutput("edge_capture", edge_capture, e.cap);
`endif
      end
   end

   // Directed test-plan sequence, then randomized pin activity.
   initial begin
      logic [W-1:0] pins;
      reset  = 1'b1;
      pin_in = 4'b1010;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset_stable",   stable_out, 4'b0000);
      checkOutput("reset_rise",     rise_pulse, 4'b0000);
      checkOutput("reset_changing", changing,   4'b0000);

      // Release with pins differing from reset value: the sixth edge after
      // release moves stable_out, with a rise pulse and no fall pulse.
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("pre_latency_stable", stable_out, 4'b0000);
      @(posedge clk);
      #1;
      checkOutput("latency_stable", stable_out, 4'b1010);
      checkOutput("latency_rise",   rise_pulse, 4'b1010);
      checkOutput("latency_fall",   fall_pulse, 4'b0000);
      #1;

      // Glitch on bit0 shorter than the debounce window.
      applyStimulus(4'b1011, 3);
      applyStimulus(4'b1010, 10);

      // Bounce on bit2 settling high.
      applyStimulus(4'b1110, 1);
      applyStimulus(4'b1010, 1);
      applyStimulus(4'b1110, 1);
      applyStimulus(4'b1010, 1);
      applyStimulus(4'b1110, 12);

      // Simultaneous opposite changes on bits 3 and 1.
      applyStimulus(4'b0110, 10);
      applyStimulus(4'b1100, 10);

      // Reset in the middle of a count; outputs clear without a clock.
      applyStimulus(4'b0011, 4);
      reset = 1'b1;
      #1;
      checkOutput("midreset_stable",   stable_out, 4'b0000);
      checkOutput("midreset_changing", changing,   4'b0000);
      checkOutput("midreset_rise",     rise_pulse, 4'b0000);
      checkOutput("midreset_fall",     fall_pulse, 4'b0000);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      applyStimulus(4'b0011, 12);

      // Random pin activity; each bit flips with probability 1/6 per cycle.
      for (int n = 0; n < 3000; n++) begin
         pins = pin_in;
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, 5) == 0) pins[b] = ~pins[b];
`ifdef GPIO_IN_EDGE_LATCH_EN
         edge_clear = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : '0;
`endif
         applyStimulus(pins, 1);
      end
`ifdef GPIO_IN_EDGE_LATCH_EN
      edge_clear = '0;
`endif
      applyStimulus(pin_in, 12);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
